// File: rtl/dcache_bridge_pkg.sv
// Shared types and constants for the data-cache to AXI bridge.
package dcache_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_e;

  // Every transfer is a single 32-bit INCR beat.
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam int WEN_W  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

endpackage

// File: rtl/axi_wr_tracker.sv
// Count of posted AXI writes still waiting for their B response.
module axi_wr_tracker
  import dcache_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING_WR = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == CNT_W'(MAX_OUTSTANDING_WR));
  assign empty = (count == '0);

endmodule

// File: rtl/dcache_axi_bridge.sv
// Single-outstanding data-cache request to AXI4 single-beat bridge.
// BRIDGE_BRESP_WAIT_EN: defined = writes complete after B; undefined = posted writes.
module dcache_axi_bridge
  import dcache_bridge_pkg::*;
#(
  parameter int ADDR_W             = 32,
  parameter int MAX_OUTSTANDING_WR = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_cache_req,
  input  logic [ADDR_W-1:0] data_cache_addr,
  input  logic [WEN_W-1:0]  data_cache_wen,
  input  logic [DATA_W-1:0] data_cache_wdata,
  output logic [DATA_W-1:0] data_cache_rdata,
  output logic              data_cache_dok,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [WEN_W-1:0]  wstrb,
  output logic              wvalid,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [WEN_W-1:0]  wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic              posted;
  logic              rd_ok;
  logic              wr_ok;

  assign araddr = addr_q & ALIGN_MASK;
  assign awaddr = addr_q & ALIGN_MASK;
  assign wdata  = wdata_q;
  assign wstrb  = wen_q;
  assign wlast  = 1'b1;

  // AW and W retire independently; a channel already handshaken counts as done.
  assign posted = (state == AWW) && (!awvalid || awready) && (!wvalid || wready);

`ifdef BRIDGE_BRESP_WAIT_EN
  assign rd_ok = 1'b1;
  assign wr_ok = 1'b1;
`else
  logic [CNT_W-1:0] wr_count;
  logic             wr_full;
  logic             wr_empty;

  axi_wr_tracker #(.MAX_OUTSTANDING_WR(MAX_OUTSTANDING_WR)) u_wr_tracker (
    .clk    (clk),
    .resetn (resetn),
    .inc    (posted),
    .dec    (bvalid && !wr_empty),
    .count  (wr_count),
    .full   (wr_full),
    .empty  (wr_empty)
  );

  // Reads wait for all posted writes to drain so they observe written data.
  assign rd_ok  = (wr_count == '0);
  assign wr_ok  = !wr_full;
  assign bready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      arvalid          <= 1'b0;
      rready           <= 1'b0;
      awvalid          <= 1'b0;
      wvalid           <= 1'b0;
      data_cache_dok   <= 1'b0;
      data_cache_rdata <= '0;
      addr_q           <= '0;
      wen_q            <= '0;
      wdata_q          <= '0;
`ifdef BRIDGE_BRESP_WAIT_EN
      bready           <= 1'b0;
`endif
    end else begin
      data_cache_dok <= 1'b0;
      case (state)
        IDLE: begin
          if (data_cache_req) begin
            if (data_cache_wen == '0) begin
              if (rd_ok) begin
                addr_q  <= data_cache_addr;
                wen_q   <= data_cache_wen;
                wdata_q <= data_cache_wdata;
                arvalid <= 1'b1;
                state   <= AR;
              end
            end else if (wr_ok) begin
              addr_q  <= data_cache_addr;
              wen_q   <= data_cache_wen;
              wdata_q <= data_cache_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= AWW;
            end
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready           <= 1'b0;
            data_cache_rdata <= rdata;
            data_cache_dok   <= 1'b1;
            state            <= RESP;
          end
        end
        AWW: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (posted) begin
`ifdef BRIDGE_BRESP_WAIT_EN
            bready <= 1'b1;
            state  <= B;
`else
            data_cache_dok <= 1'b1;
            state          <= RESP;
`endif
          end
        end
        B: begin
`ifdef BRIDGE_BRESP_WAIT_EN
          if (bvalid) begin
            bready         <= 1'b0;
            data_cache_dok <= 1'b1;
            state          <= RESP;
          end
`else
          state <= IDLE;
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge in its default (posted-write) build.
module tb_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_cache_req;
  logic [31:0] data_cache_addr;
  logic [3:0]  data_cache_wen;
  logic [31:0] data_cache_wdata;
  logic [31:0] data_cache_rdata;
  logic        data_cache_dok;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wlast;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int n_cmp = 0;
  int n_err = 0;
  int dok_cnt = 0;
  int base;

  always #5 clk = ~clk;

  dcache_axi_bridge dut (
    .clk              (clk),
    .resetn           (resetn),
    .data_cache_req   (data_cache_req),
    .data_cache_addr  (data_cache_addr),
    .data_cache_wen   (data_cache_wen),
    .data_cache_wdata (data_cache_wdata),
    .data_cache_rdata (data_cache_rdata),
    .data_cache_dok   (data_cache_dok),
    .araddr           (araddr),
    .arvalid          (arvalid),
    .arready          (arready),
    .rdata            (rdata),
    .rvalid           (rvalid),
    .rready           (rready),
    .awaddr           (awaddr),
    .awvalid          (awvalid),
    .awready          (awready),
    .wdata            (wdata),
    .wstrb            (wstrb),
    .wvalid           (wvalid),
    .wlast            (wlast),
    .wready           (wready),
    .bvalid           (bvalid),
    .bready           (bready)
  );

  // dok pulses are tallied one edge after they appear.
  always @(posedge clk) if (data_cache_dok === 1'b1) dok_cnt++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    data_cache_req = 1'b0; data_cache_addr = '0; data_cache_wen = '0; data_cache_wdata = '0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    repeat (3) tick();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid",  32'(wvalid),  32'd0);
    chk("rst_rready",  32'(rready),  32'd0);
    chk("rst_dok",     32'(data_cache_dok), 32'd0);
    chk("rst_rdata",   data_cache_rdata, 32'd0);
    chk("bready_tied", 32'(bready), 32'd1);
    chk("wlast_tied",  32'(wlast),  32'd1);
    resetn = 1'b1;
    tick();

    // Read, arready immediate, rvalid two cycles later
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h1FC0_0004; data_cache_wen = 4'h0; arready = 1'b1;
    tick();
    chk("rd_arvalid", 32'(arvalid), 32'd1);
    chk("rd_araddr",  araddr, 32'h1FC0_0004);
    tick();
    chk("rd_arvalid_drop", 32'(arvalid), 32'd0);
    chk("rd_rready", 32'(rready), 32'd1);
    arready = 1'b0;
    tick();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_dok",   32'(data_cache_dok), 32'd1);
    chk("rd_rdata", data_cache_rdata, 32'hDEAD_BEEF);
    data_cache_req = 1'b0; rvalid = 1'b0;
    tick();
    chk("rd_dok_pulse", 32'(data_cache_dok), 32'd0);
    chk("rd_rready_drop", 32'(rready), 32'd0);
    tick();
    chk("rd_dok_count", 32'(dok_cnt - base), 32'd1);

    // Write, wready three cycles ahead of awready
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h0000_1000; data_cache_wen = 4'b0011;
    data_cache_wdata = 32'h1234_5678;
    tick();
    chk("wr_awvalid", 32'(awvalid), 32'd1);
    chk("wr_wvalid",  32'(wvalid),  32'd1);
    chk("wr_awaddr",  awaddr, 32'h0000_1000);
    chk("wr_wstrb",   32'(wstrb), 32'b0011);
    chk("wr_wdata",   wdata, 32'h1234_5678);
    wready = 1'b1;
    tick();
    chk("wr_wvalid_drop", 32'(wvalid), 32'd0);
    chk("wr_awvalid_hold1", 32'(awvalid), 32'd1);
    wready = 1'b0;
    tick();
    chk("wr_awvalid_hold2", 32'(awvalid), 32'd1);
    chk("wr_no_dok", 32'(data_cache_dok), 32'd0);
    tick();
    chk("wr_awvalid_hold3", 32'(awvalid), 32'd1);
    awready = 1'b1;
    tick();
    chk("wr_dok", 32'(data_cache_dok), 32'd1);
    chk("wr_awvalid_drop", 32'(awvalid), 32'd0);
    awready = 1'b0; data_cache_req = 1'b0;
    tick();
    chk("wr_dok_pulse", 32'(data_cache_dok), 32'd0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("wr_dok_count", 32'(dok_cnt - base), 32'd1);

    // Write-back then line-fill with req held; read waits for bvalid
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h0000_2000; data_cache_wen = 4'hF;
    data_cache_wdata = 32'hA5A5_A5A5; awready = 1'b1; wready = 1'b1;
    tick();
    chk("wbl_awvalid", 32'(awvalid), 32'd1);
    chk("wbl_wvalid",  32'(wvalid),  32'd1);
    tick();
    chk("wbl_wr_dok", 32'(data_cache_dok), 32'd1);
    data_cache_wen = 4'h0; data_cache_addr = 32'h0000_3000; awready = 1'b0; wready = 1'b0;
    tick();
    chk("wbl_idle_no_ar", 32'(arvalid), 32'd0);
    tick();
    chk("wbl_ar_withheld1", 32'(arvalid), 32'd0);
    tick();
    chk("wbl_ar_withheld2", 32'(arvalid), 32'd0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("wbl_ar_withheld3", 32'(arvalid), 32'd0);
    tick();
    chk("wbl_arvalid", 32'(arvalid), 32'd1);
    chk("wbl_araddr",  araddr, 32'h0000_3000);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    chk("wbl_rd_dok",   32'(data_cache_dok), 32'd1);
    chk("wbl_rd_rdata", data_cache_rdata, 32'hCAFE_F00D);
    data_cache_req = 1'b0; rvalid = 1'b0;
    tick();
    tick();
    chk("wbl_dok_count", 32'(dok_cnt - base), 32'd2);

    // Three posted writes without B responses, fourth stalls
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h0000_5000; data_cache_wen = 4'hF;
    data_cache_wdata = 32'h0101_0202; awready = 1'b1; wready = 1'b1;
    repeat (12) tick();
    chk("lim_dok_count3", 32'(dok_cnt - base), 32'd3);
    chk("lim_stalled", 32'(awvalid), 32'd0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("lim_still_stalled", 32'(awvalid), 32'd0);
    tick();
    chk("lim_released", 32'(awvalid), 32'd1);
    tick();
    chk("lim_4th_dok", 32'(data_cache_dok), 32'd1);
    data_cache_req = 1'b0; bvalid = 1'b1;
    repeat (3) tick();
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    tick();
    chk("lim_dok_count4", 32'(dok_cnt - base), 32'd4);

    // Reset while a write is waiting in AWW
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h0000_6000; data_cache_wen = 4'hF;
    tick();
    chk("rstm_awvalid", 32'(awvalid), 32'd1);
    resetn = 1'b0;
    tick();
    chk("rstm_awvalid_drop", 32'(awvalid), 32'd0);
    chk("rstm_wvalid_drop",  32'(wvalid),  32'd0);
    chk("rstm_dok", 32'(data_cache_dok), 32'd0);
    resetn = 1'b1; data_cache_req = 1'b0;
    tick();
    chk("rstm_idle_awvalid", 32'(awvalid), 32'd0);
    tick();
    chk("rstm_no_dok", 32'(dok_cnt - base), 32'd0);

    // arready held low: unaligned address zeroed, arvalid/araddr stable
    base = dok_cnt;
    data_cache_req = 1'b1; data_cache_addr = 32'h4000_000B; data_cache_wen = 4'h0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_arvalid", 32'(arvalid), 32'd1);
      chk("stall_araddr",  araddr, 32'h4000_0008);
      chk("stall_no_dok",  32'(data_cache_dok), 32'd0);
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    chk("stall_dok",   32'(data_cache_dok), 32'd1);
    chk("stall_rdata", data_cache_rdata, 32'h0BAD_F00D);
    data_cache_req = 1'b0; rvalid = 1'b0;
    tick();
    tick();
    chk("stall_dok_count", 32'(dok_cnt - base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
DCACHE_AXI_BRIDGE -- requirements
Module: dcache_axi_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI/cache address width.
REQ-002 SHALL have parameter MAX_OUTSTANDING_WR, default 3, posted-write limit (range 1..3).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 data_cache_req  input  1  cache request, level, held until dok.
REQ-006 data_cache_addr  input  ADDR_W  request address, stable while req.
REQ-007 data_cache_wen  input  4  byte enables; 0 = read, nonzero = write.
REQ-008 data_cache_wdata  input  32  write data, stable while req.
REQ-009 data_cache_rdata  output  32  read data, valid only in dok cycle.
REQ-010 data_cache_dok  output  1  one-cycle completion pulse.
REQ-011 araddr/arvalid (out ADDR_W/1), arready (in 1)  AXI read address channel.
REQ-012 rdata/rvalid (in 32/1), rready (out 1)  AXI read data channel.
REQ-013 awaddr/awvalid (out ADDR_W/1), awready (in 1)  AXI write address channel.
REQ-014 wdata/wstrb/wvalid (out 32/4/1), wready (in 1)  AXI write data; single beat, wlast tied 1 at top.
REQ-015 bvalid (in 1), bready (out 1)  AXI write response channel.

Function
REQ-016 SHALL use FSM states IDLE, AR, R, AWW, B, RESP; only one cache request is in service at a time.
REQ-017 IDLE: req && wen==0 -> AR; req && wen!=0 -> AWW; else stay. Request fields are captured into registers on leaving IDLE.
REQ-018 AR: arvalid=1, araddr={addr[ADDR_W-1:2],2'b00}; arready -> R.
REQ-019 R: rready=1; rvalid -> RESP, rdata captured into data_cache_rdata.
REQ-020 AWW: awvalid and wvalid rise together, each drops independently on its own handshake; wstrb=wen; awaddr=addr unaligned-low bits zeroed. Both done -> B (macro on) or RESP (macro off).
REQ-021 B: bready=1; bvalid -> RESP.
REQ-022 RESP: data_cache_dok=1 for exactly one cycle -> IDLE; req is not sampled in RESP.
REQ-023 Back-to-back requests: req still high in the IDLE cycle after RESP is a new request (write-back then line-fill) and is accepted that cycle; minimum spacing between dok pulses is 1 idle cycle.
REQ-024 valid signals, once asserted, SHALL stay high until handshake (AXI rule); address/data SHALL not change while valid.
REQ-025 rresp/bresp ignored; no error reporting.
REQ-026 req deasserted mid-transaction is a protocol violation; the bridge completes the AXI transaction and pulses dok regardless.

Reset
REQ-027 Reset SHALL force state IDLE and all valids, dok, rready, bready(macro on) to 0; data_cache_rdata to 0; outstanding counter to 0.
REQ-028 Reset mid-transaction SHALL drop valids in the next cycle without completing; the interconnect is reset with the bridge.

Configuration
REQ-029 Macro BRIDGE_BRESP_WAIT_EN defined: writes complete (dok) only after B handshake; bready driven only in state B.
REQ-030 Macro undefined: writes are posted -- dok after AW and W both handshake; bready tied 1; outstanding counter +1 on write posting, -1 on bvalid, simultaneous inc/dec leaves it unchanged.
REQ-031 Macro undefined: IDLE SHALL not leave for AR while counter != 0 (read-after-write ordering), nor for AWW while counter == MAX_OUTSTANDING_WR; state B is unreachable.

Structure
REQ-032 Shared package dcache_bridge_pkg SHALL hold FSM state enum, AXI size/burst/len constants, and the cache request field widths.
REQ-033 Outstanding-write counter SHALL be the sub-module axi_wr_tracker (inc, dec, count, full, empty), instantiated only when the macro is undefined.

Verification
REQ-034 Read addr 0x1FC0_0004, arready=1 immediately, rvalid 2 cycles later rdata=0xDEADBEEF -> araddr=0x1FC0_0004, one dok with rdata 0xDEADBEEF.
REQ-035 Write addr 0x0000_1000 wen=4'b0011 wdata=0x1234_5678, wready 3 cycles before awready -> wvalid drops first, awvalid held, wstrb=0011, single dok.
REQ-036 Write then read held high across dok (WB->LM) -> read issued in the IDLE cycle after RESP; macro off: AR withheld until bvalid returns.
REQ-037 Macro off, 3 posted writes with bvalid held 0 -> 4th write stalls in IDLE; one bvalid releases it.
REQ-038 resetn low while in AWW with awvalid=1 -> next cycle all valids 0, state IDLE, no dok.
REQ-039 arready held 0 for 10 cycles -> arvalid and araddr stable throughout, no dok.
